// File: rtl/logic16_pkg.sv
// logic16_pkg: widths and constants shared by the acquisition control block and the sample packer.
package logic16_pkg;
  localparam int NUM_CH = 16;
  localparam int BLOCK_LEN = 16;
  localparam int CHAN_IDX_W = 4;
  localparam int DIV_W = 8;
  typedef logic [BLOCK_LEN-1:0] word_t;
endpackage

// File: rtl/lowest_set_index.sv
// lowest_set_index: combinational priority encoder returning the lowest set bit of a mask and a non-empty flag.
module lowest_set_index #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (mask[i]) idx = W'(i);
  end
  assign any = |mask;
endmodule

// File: rtl/sample_packer.sv
// sample_packer: decimates the channel bus, packs 16 samples per channel into words and drains them in channel order.
// Optional SAMPLE_PACKER_TEST_PATTERN_EN replaces sample_in with a per-strobe counter.
import logic16_pkg::*;
module sample_packer #(
  parameter int NUM_CH = logic16_pkg::NUM_CH,
  parameter int DIV_W = logic16_pkg::DIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acq_enable,
  input  logic                  acq_reset,
  input  logic [DIV_W-1:0]      clock_divisor,
  input  logic [NUM_CH-1:0]     channel_enable,
  input  logic [NUM_CH-1:0]     sample_in,
  output word_t                 out_data,
  output logic [CHAN_IDX_W-1:0] out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  fifo_overflow
);
  logic [DIV_W-1:0] cnt;
  logic [CHAN_IDX_W-1:0] bidx;
  logic [NUM_CH-1:0] lat_mask, dmask, sel, smp;
  logic [NUM_CH-1:0][BLOCK_LEN-1:0] col, col_nxt, drn;
  logic en_q, strobe, acc, last, done, take;
  assign strobe = acq_enable && cnt == '0;
  assign acc = out_valid && out_ready;
  assign sel = NUM_CH'(1) << out_chan;
  assign last = acc && (dmask & ~sel) == '0;
  assign done = strobe && bidx == CHAN_IDX_W'(BLOCK_LEN - 1);
  assign take = done && (dmask == '0 || last);
  assign out_data = drn[out_chan];
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  logic [BLOCK_LEN-1:0] pat;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pat <= '0;
    else if (acq_reset) pat <= '0;
    else if (strobe) pat <= pat + 1'b1;
  assign smp = pat[NUM_CH-1:0];
`else
  assign smp = sample_in;
`endif
  always_comb begin
    col_nxt = col;
    for (int c = 0; c < NUM_CH; c++) col_nxt[c][bidx] = strobe ? smp[c] : col[c][bidx];
  end
  lowest_set_index #(.N(NUM_CH), .W(CHAN_IDX_W)) u_lsi (
    .mask(dmask),
    .idx (out_chan),
    .any (out_valid)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= 1'b0;
      cnt <= '0;
      bidx <= '0;
      col <= '0;
      drn <= '0;
      lat_mask <= '0;
      dmask <= '0;
      fifo_overflow <= 1'b0;
    end else if (acq_reset) begin
      en_q <= acq_enable;
      cnt <= '0;
      bidx <= '0;
      col <= '0;
      drn <= '0;
      lat_mask <= '0;
      dmask <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      en_q <= acq_enable;
      cnt <= (acq_enable && cnt < clock_divisor) ? cnt + 1'b1 : '0;
      if (acq_enable && !en_q) lat_mask <= channel_enable;
      col <= col_nxt;
      // leaving acq_enable low parks the index at 0, discarding any partial block
      bidx <= !acq_enable ? '0 : strobe ? bidx + 1'b1 : bidx;
      if (take) drn <= col_nxt;
      dmask <= take ? lat_mask : acc ? dmask & ~sel : dmask;
      if (done && !take) fifo_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed self-checking bench for sample_packer.
// Build with SAMPLE_PACKER_TEST_PATTERN_EN to exercise the counter pattern instead of sample_in.
module tb_sample_packer;
  import logic16_pkg::*;
  logic clk = 0, rst = 0, acq_enable = 0, acq_reset = 0, out_ready = 0;
  logic [DIV_W-1:0] clock_divisor = '0;
  logic [NUM_CH-1:0] channel_enable = '0, sample_in = '0;
  logic [15:0] out_data;
  logic [3:0] out_chan;
  logic out_valid, fifo_overflow;
  int tests = 0, fails = 0, words = 0, first = -1, last = -1, bad = 0;
  logic [15:0] s [16];
  always #5 clk = ~clk;
  sample_packer dut (
    .clk(clk), .rst(rst), .acq_enable(acq_enable), .acq_reset(acq_reset),
    .clock_divisor(clock_divisor), .channel_enable(channel_enable), .sample_in(sample_in),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_overflow(fifo_overflow)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] exp_word(input int c);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[k] = s[k][c];
    return w;
  endfunction
  initial begin
    for (int k = 0; k < 16; k++) s[k] = 16'(k * 16'h0F0F + 16'h1357);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);
    check("rst_ovf", fifo_overflow, 0);
    step(2);
    rst = 1;
    step(1);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    channel_enable = 16'h0001;
    acq_enable = 1;
    step(16);
    check("tp_valid", out_valid, 1);
    check("tp_chan", out_chan, 0);
    check("tp_data", out_data, 16'hAAAA);
    acq_enable = 0;
    out_ready = 1;
    step(1);
    check("tp_drained", out_valid, 0);
    channel_enable = 16'h0010;
    acq_enable = 1;
    step(16);
    check("tp2_valid", out_valid, 1);
    check("tp2_chan", out_chan, 4);
    check("tp2_data", out_data, 16'hFFFF);
    acq_enable = 0;
    acq_reset = 1;
    step(1);
    acq_reset = 0;
    check("tp_ar_valid", out_valid, 0);
    check("tp_ar_ovf", fifo_overflow, 0);
`else
    // single channel, toggling input
    channel_enable = 16'h0001;
    acq_enable = 1;
    for (int k = 0; k < 16; k++) begin
      sample_in = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      if (k == 15) check("a_valid_early", out_valid, 0);
      step(1);
    end
    check("a_valid", out_valid, 1);
    check("a_data", out_data, 16'h5555);
    check("a_chan", out_chan, 0);
    acq_enable = 0;
    out_ready = 1;
    step(1);
    check("a_drained", out_valid, 0);
    // sparse mask with divisor 3: 16th strobe lands 60 cycles after the first
    channel_enable = 16'h8005;
    clock_divisor = 3;
    acq_enable = 1;
    for (int k = 0; k < 15; k++) begin
      sample_in = s[k];
      step(4);
    end
    sample_in = s[15];
    check("b_valid_early", out_valid, 0);
    step(1);
    check("b_chan0", out_chan, 0);
    check("b_data0", out_data, exp_word(0));
    step(1);
    check("b_chan2", out_chan, 2);
    check("b_data2", out_data, exp_word(2));
    step(1);
    check("b_chan15", out_chan, 15);
    check("b_data15", out_data, exp_word(15));
    step(1);
    check("b_done", out_valid, 0);
    check("b_ovf", fifo_overflow, 0);
    acq_enable = 0;
    // full mask, divisor 0, sustained drain
    clock_divisor = 0;
    channel_enable = 16'hFFFF;
    sample_in = 16'h00FF;
    step(1);
    acq_enable = 1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (i == 63) acq_enable = 0;
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        if (out_chan !== 4'(words % 16) || out_data !== (((words % 16) < 8) ? 16'hFFFF : 16'h0000)) bad++;
        words++;
      end
    end
    check("c_words", words, 64);
    check("c_first", first, 15);
    check("c_span", last - first, 63);
    check("c_order", bad, 0);
    check("c_ovf", fifo_overflow, 0);
    // stalled consumer: second block is dropped, first drains intact
    out_ready = 0;
    acq_enable = 1;
    for (int k = 0; k < 16; k++) begin
      sample_in = s[k];
      step(1);
    end
    check("d_valid", out_valid, 1);
    check("d_ovf_early", fifo_overflow, 0);
    sample_in = 16'h5A5A;
    step(16);
    check("d_ovf", fifo_overflow, 1);
    check("d_hold_chan", out_chan, 0);
    check("d_hold_data", out_data, exp_word(0));
    acq_enable = 0;
    out_ready = 1;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (!out_valid || out_chan !== 4'(c) || out_data !== exp_word(c)) bad++;
      step(1);
    end
    check("d_drain", bad, 0);
    check("d_empty", out_valid, 0);
    check("d_sticky", fifo_overflow, 1);
    // acq_reset clears overflow and a pending word
    out_ready = 0;
    channel_enable = 16'h0001;
    acq_enable = 1;
    step(16);
    check("e_valid_pre", out_valid, 1);
    acq_reset = 1;
    acq_enable = 0;
    step(1);
    acq_reset = 0;
    check("e_ovf", fifo_overflow, 0);
    check("e_valid", out_valid, 0);
    // empty latched mask
    channel_enable = 16'h0000;
    acq_enable = 1;
    step(40);
    check("z_valid", out_valid, 0);
    check("z_ovf", fifo_overflow, 0);
    acq_enable = 0;
    step(1);
    // mask change mid-run ignored until next rising edge
    channel_enable = 16'h0002;
    sample_in = 16'h0003;
    out_ready = 1;
    acq_enable = 1;
    step(4);
    channel_enable = 16'h0001;
    step(12);
    check("m_valid", out_valid, 1);
    check("m_chan", out_chan, 1);
    check("m_data", out_data, 16'hFFFF);
    step(1);
    check("m_only_one", out_valid, 0);
    acq_enable = 0;
    step(1);
    acq_enable = 1;
    step(16);
    check("m_relatch_chan", out_chan, 0);
    check("m_relatch_valid", out_valid, 1);
    // asynchronous reset while a word is pending
    acq_enable = 0;
    out_ready = 0;
    step(16);
    check("r_pre", out_valid, 1);
    #2;
    rst = 0;
    #1;
    check("r_valid", out_valid, 0);
    check("r_data", out_data, 0);
    step(1);
    rst = 1;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
